// File: rtl/clint_timer_pkg.sv
// clint_timer_pkg: CLINT register offsets, reset constants and offset decode helper
package clint_timer_pkg;
  localparam logic [15:0] CLINT_MSIP_OFF        = 16'h0000;
  localparam logic [15:0] CLINT_MTIMECMP_OFF    = 16'h4000;
  localparam logic [15:0] CLINT_MTIMECMP_HI_OFF = 16'h4004;
  localparam logic [15:0] CLINT_MTIME_OFF       = 16'hBFF8;
  localparam logic [15:0] CLINT_MTIME_HI_OFF    = 16'hBFFC;
  localparam logic [63:0] MTIMECMP_RST          = 64'hFFFF_FFFF_FFFF_FFFF;

  function automatic logic hit(input logic [15:0] off, input logic [15:0] base);
    return off[15:2] == base[15:2];
  endfunction
endpackage

// File: rtl/clint_prescaler.sv
// clint_prescaler: divides clk by TICK_DIV, one-cycle tick on the last count
module clint_prescaler #(
  parameter int unsigned TICK_DIV = 27
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);
  logic [15:0] cnt;
  assign tick = cnt == 16'(TICK_DIV - 1);
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt <= '0;
    else cnt <= tick ? '0 : cnt + 16'd1;
endmodule

// File: rtl/clint_timer.sv
// clint_timer: CLINT with prescaled 64-bit mtime, mtimecmp and msip.
// CLINT_SNAPSHOT_EN: lo read of mtime latches hi into a shadow for tear-free 64-bit reads.
module clint_timer
  import clint_timer_pkg::*;
#(
  parameter int unsigned TICK_DIV = 27
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_in,
  input  logic        clint_ren,
  input  logic        clint_wen,
  output logic [31:0] clint_data_out,
  output logic        timer_irq,
  output logic        soft_irq
);
  logic        tick, msip;
  logic [63:0] mtime, mtimecmp, mtime_nxt;
  logic [31:0] rdata, mtime_hi_rd;
  logic [15:0] off;
  logic        sel_msip, sel_cmp_lo, sel_cmp_hi, sel_mt_lo, sel_mt_hi;
  logic        unused_addr;

  clint_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (.clk(clk), .reset(reset), .tick(tick));

  assign off         = data_addr[15:0];
  assign unused_addr = ^{data_addr[31:16], data_addr[1:0]};
  assign sel_msip    = hit(off, CLINT_MSIP_OFF);
  assign sel_cmp_lo  = hit(off, CLINT_MTIMECMP_OFF);
  assign sel_cmp_hi  = hit(off, CLINT_MTIMECMP_HI_OFF);
  assign sel_mt_lo   = hit(off, CLINT_MTIME_OFF);
  assign sel_mt_hi   = hit(off, CLINT_MTIME_HI_OFF);
  assign soft_irq    = msip;

  // A write to either half suppresses the tick entirely, so no carry leaks into the other half
  always_comb
    mtime_nxt = (clint_wen && (sel_mt_lo || sel_mt_hi))
              ? {sel_mt_hi ? data_in : mtime[63:32], sel_mt_lo ? data_in : mtime[31:0]}
              : tick ? mtime + 64'd1 : mtime;

  always_comb
    rdata = sel_msip   ? {31'd0, msip}
          : sel_cmp_lo ? mtimecmp[31:0]
          : sel_cmp_hi ? mtimecmp[63:32]
          : sel_mt_lo  ? mtime[31:0]
          : sel_mt_hi  ? mtime_hi_rd
          : '0;

`ifdef CLINT_SNAPSHOT_EN
  logic [31:0] shadow;
  always_ff @(posedge clk or posedge reset)
    if (reset) shadow <= '0;
    else if (clint_wen && sel_mt_hi) shadow <= data_in;
    else if (clint_ren && sel_mt_lo) shadow <= mtime[63:32];
  assign mtime_hi_rd = shadow;
`else
  assign mtime_hi_rd = mtime[63:32];
`endif

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      mtime          <= '0;
      mtimecmp       <= MTIMECMP_RST;
      msip           <= 1'b0;
      clint_data_out <= '0;
      timer_irq      <= 1'b0;
    end else begin
      mtime     <= mtime_nxt;
      timer_irq <= mtime >= mtimecmp;
      if (clint_wen && sel_cmp_lo) mtimecmp[31:0] <= data_in;
      if (clint_wen && sel_cmp_hi) mtimecmp[63:32] <= data_in;
      if (clint_wen && sel_msip) msip <= data_in[0];
      if (clint_ren) clint_data_out <= rdata;
    end
endmodule

// File: tb/tb_clint_timer.sv
// tb_clint_timer: scoreboard bench; u_a runs TICK_DIV=4, u_b runs TICK_DIV=1 for snapshot reads
module tb_clint_timer;
  localparam logic [15:0] MSIP = 16'h0000, CMP_LO = 16'h4000, CMP_HI = 16'h4004;
  localparam logic [15:0] MT_LO = 16'hBFF8, MT_HI = 16'hBFFC, UNMAP = 16'h0008;

  logic        clk = 0;
  logic        a_rst = 1, b_rst = 1;
  logic [31:0] a_addr = 0, a_din = 0, b_addr = 0, b_din = 0;
  logic        a_ren = 0, a_wen = 0, b_ren = 0, b_wen = 0;
  logic [31:0] a_dout, b_dout;
  logic        a_tirq, a_sirq, b_tirq, b_sirq;
  logic [31:0] exp_q[$];
  int          checks = 0, failures = 0;
  logic        found;

  always #5 clk = ~clk;

  clint_timer #(.TICK_DIV(4)) u_a (
    .clk(clk), .reset(a_rst), .data_addr(a_addr), .data_in(a_din),
    .clint_ren(a_ren), .clint_wen(a_wen), .clint_data_out(a_dout),
    .timer_irq(a_tirq), .soft_irq(a_sirq));

  clint_timer #(.TICK_DIV(1)) u_b (
    .clk(clk), .reset(b_rst), .data_addr(b_addr), .data_in(b_din),
    .clint_ren(b_ren), .clint_wen(b_wen), .clint_data_out(b_dout),
    .timer_irq(b_tirq), .soft_irq(b_sirq));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit f, input logic [15:0] off, input logic [31:0] d, input bit r, input bit w);
    if (f) begin
      b_addr = {16'h0200, off}; b_din = d; b_ren = r; b_wen = w;
    end else begin
      a_addr = {16'h0200, off}; a_din = d; a_ren = r; a_wen = w;
    end
  endtask

  task automatic wr(input bit f, input logic [15:0] off, input logic [31:0] d);
    @(negedge clk);
    drive(f, off, d, 1'b0, 1'b1);
    step();
    drive(f, 16'h0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic rd(input bit f, input string tag, input logic [15:0] off, input logic [31:0] exp,
                    input bit w = 1'b0, input logic [31:0] d = 32'h0);
    @(negedge clk);
    exp_q.push_back(exp);
    drive(f, off, d, 1'b1, w);
    step();
    drive(f, 16'h0, 32'h0, 1'b0, 1'b0);
    check(tag, f ? b_dout : a_dout, exp_q.pop_front());
  endtask

  task automatic wait_tick();
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      found = u_a.tick;
    end
    check("tick_seen", found, 1);
  endtask

  initial begin
    #1;
    check("rst_dout", a_dout, 0);
    check("rst_tirq", a_tirq, 0);
    check("rst_sirq", a_sirq, 0);
    @(negedge clk);
    a_rst = 0;
    b_rst = 0;
    // 1: idle 40 clk at TICK_DIV=4 -> 10 ticks
    repeat (40) @(posedge clk);
    #1;
    check("idle_tirq", a_tirq, 0);
    rd(0, "idle_mtime", MT_LO, 32'd10);
    rd(0, "rst_cmp_lo", CMP_LO, 32'hFFFF_FFFF);
    rd(0, "rst_cmp_hi", CMP_HI, 32'hFFFF_FFFF);
    // 2: compare rise/fall timing
    wr(0, MT_LO, 32'h0);
    wr(0, CMP_LO, 32'd5);
    wr(0, CMP_HI, 32'd0);
    found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      step();
      found = u_a.mtime == 64'd5;
    end
    check("mt5_seen", found, 1);
    check("tirq_at5", a_tirq, 0);
    step();
    check("tirq_rise", a_tirq, 1);
    wr(0, CMP_LO, 32'd100);
    check("tirq_hold", a_tirq, 1);
    step();
    check("tirq_fall", a_tirq, 0);
    // 3: lo carry into hi, then full wrap
    wr(0, MT_HI, 32'h0);
    wr(0, MT_LO, 32'hFFFF_FFFF);
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      step();
      found = u_a.mtime[31:0] != 32'hFFFF_FFFF;
    end
    check("carry_seen", found, 1);
    rd(0, "carry_lo", MT_LO, 32'h0);
    rd(0, "carry_hi", MT_HI, 32'h1);
    wr(0, MT_HI, 32'hFFFF_FFFF);
    wr(0, MT_LO, 32'hFFFF_FFFF);
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      step();
      found = u_a.mtime == 64'h0;
    end
    check("wrap_seen", found, 1);
    check("wrap_tirq_old", a_tirq, 1);
    step();
    check("wrap_tirq_new", a_tirq, 0);
    rd(0, "wrap_lo", MT_LO, 32'h0);
    rd(0, "wrap_hi", MT_HI, 32'h0);
    // 4: write coinciding with tick wins and applies no carry
    wait_tick();
    wr(0, MT_LO, 32'hFFFF_FFFF);
    wait_tick();
    wr(0, MT_LO, 32'h1234);
    rd(0, "wtick_lo", MT_LO, 32'h1234);
    rd(0, "wtick_hi", MT_HI, 32'h0);
    // 5: msip and unmapped offsets
    wr(0, MSIP, 32'h1);
    check("sirq_set", a_sirq, 1);
    rd(0, "msip_rd1", MSIP, 32'h1);
    wr(0, MSIP, 32'h0);
    check("sirq_clr", a_sirq, 0);
    rd(0, "unmap_rd", UNMAP, 32'h0);
    wr(0, UNMAP, 32'hFFFF_FFFF);
    rd(0, "msip_rd0", MSIP, 32'h0);
    check("unmap_sirq", a_sirq, 0);
    rd(0, "unmap_cmp_lo", CMP_LO, 32'd100);
    rd(0, "unmap_cmp_hi", CMP_HI, 32'd0);
    rd(0, "rw_same_old", CMP_LO, 32'd100, 1'b1, 32'd200);
    rd(0, "rw_same_new", CMP_LO, 32'd200);
    // 6: lo-then-hi read across a carry at TICK_DIV=1
    wr(1, MT_HI, 32'h0);
    wr(1, MT_LO, 32'hFFFF_FFFF);
    rd(1, "snap_lo", MT_LO, 32'hFFFF_FFFF);
`ifdef CLINT_SNAPSHOT_EN
    rd(1, "snap_hi", MT_HI, 32'h0);
`else
    rd(1, "torn_hi", MT_HI, 32'h1);
`endif
    // asynchronous reset mid-count
    wr(0, MSIP, 32'h1);
    rd(0, "pre_rst_cmp", CMP_LO, 32'd200);
    check("pre_rst_tirq", a_tirq, 1);
    @(negedge clk);
    #2;
    a_rst = 1;
    #1;
    check("arst_dout", a_dout, 0);
    check("arst_tirq", a_tirq, 0);
    check("arst_sirq", a_sirq, 0);
    @(negedge clk);
    a_rst = 0;
    rd(0, "arst_cmp_lo", CMP_LO, 32'hFFFF_FFFF);
    rd(0, "arst_cmp_hi", CMP_HI, 32'hFFFF_FFFF);
    rd(0, "arst_mtime", MT_LO, 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
